load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: splits word/byte CPU accesses into beats on a byte-wide memory.
// Optional feature macro LSU_SIGNED_LOAD_EN enables sign extension of byte loads.
module load_store_unit #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic                     req_byte,
    input  logic                     req_signed,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     mem_we,
    input  logic [7:0]               mem_rdata
);

    typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               beat_q, beat_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic                     byte_q, byte_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              rbuf_q, rbuf_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]    byte_ext;
    logic                     last_beat;

`ifdef LSU_SIGNED_LOAD_EN
    logic signed_q, signed_d;
`else
    logic unused_signed;
    assign unused_signed = req_signed;
`endif

    assign last_beat = byte_q ? (beat_q == 2'd0) : (beat_q == 2'd3);

    always_comb begin
        byte_ext = DATA_WIDTH'(mem_rdata);
`ifdef LSU_SIGNED_LOAD_EN
        if (signed_q) begin
            byte_ext = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        we_d     = we_q;
        byte_d   = byte_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
`ifdef LSU_SIGNED_LOAD_EN
        signed_d = signed_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    byte_d   = req_byte;
                    wdata_d  = req_wdata[31:0];
`ifdef LSU_SIGNED_LOAD_EN
                    signed_d = req_signed;
`endif
                    beat_d   = 2'd0;
                    state_d  = StXfer;
                end
            end
            StXfer: begin
                if (!we_q) begin
                    rbuf_d[{beat_q, 3'b000} +: 8] = mem_rdata;
                end
                if (last_beat) begin
                    state_d = StResp;
                    // Result register only moves on load completion so it stays stable across stores.
                    if (!we_q) begin
                        rdata_d = byte_q ? byte_ext : DATA_WIDTH'(rbuf_d);
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (state_q == StXfer) begin
            mem_we    = we_q;
            mem_addr  = addr_q + ADDRESS_WIDTH'(beat_q);
            mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            beat_q   <= 2'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            wdata_q  <= 32'h0;
            rbuf_q   <= 32'h0;
            rdata_q  <= '0;
`ifdef LSU_SIGNED_LOAD_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            byte_q   <= byte_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
`ifdef LSU_SIGNED_LOAD_EN
            signed_q <= signed_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte memory model, latency/data checks, write log.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_byte, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we;

    load_store_unit #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        int          lat;
        logic [31:0] exp;
        int          acc;
    } sb_t;

    sb_t         sb_q[$];
    logic [39:0] wlog[$];
    logic [7:0]  tb_mem [4096];
    logic [7:0]  ref_mem[4096];
    logic [31:0] last_load;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    assign mem_rdata = tb_mem[mem_addr[11:0]];

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[11:0]] <= mem_wdata;
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) wlog.push_back({mem_addr, mem_wdata});
        if (rsp_valid) begin
            sb_t e;
            check_eq("rsp_mem_we", mem_we, 0);
            check_eq("rsp_ready", req_ready, 0);
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("latency", cyc - e.acc, e.lat);
                check_eq(e.is_load ? "load_rdata" : "store_rdata", rsp_rdata, e.exp);
            end
        end
    end

    function automatic logic [31:0] model_load(input logic byt, input logic sgn,
                                               input logic [31:0] addr);
        logic [31:0] w;
        logic [7:0]  b;
        logic [11:0] a;
        a = addr[11:0];
        b = ref_mem[a];
        if (byt) begin
`ifdef LSU_SIGNED_LOAD_EN
            if (sgn) return {{24{b[7]}}, b};
`endif
            return {24'h0, b};
        end
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = ref_mem[a + 12'(k)];
        return w;
    endfunction

    task automatic lsu_req(input logic we, input logic byt, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit hold, output int acc, output int waited);
        sb_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_byte = byt; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check_eq("accept", req_ready, 1);
        acc = cyc;
        e.is_load = !we;
        e.lat = byt ? 2 : 5;
        e.acc = cyc;
        if (!we) begin
            e.exp = model_load(byt, sgn, addr);
            last_load = e.exp;
        end else begin
            e.exp = last_load;
            for (int k = 0; k < (byt ? 1 : 4); k++) ref_mem[addr[11:0] + 12'(k)] = wdata[k*8 +: 8];
        end
        sb_q.push_back(e);
        if (!hold) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check_eq("drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, wt;
        logic [31:0] a_exp[4];
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_load = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);

        // Word store then word load at the same address
        wlog.delete();
        lsu_req(1, 0, 0, 32'h0001_0000, 32'hDEAD_BEEF, 0, acc1, wt);
        drain();
        check_eq("st_writes", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check_eq("st_b0", wlog[0], {32'h0001_0000, 8'hEF});
            check_eq("st_b1", wlog[1], {32'h0001_0001, 8'hBE});
            check_eq("st_b2", wlog[2], {32'h0001_0002, 8'hAD});
            check_eq("st_b3", wlog[3], {32'h0001_0003, 8'hDE});
        end
        wlog.delete();
        lsu_req(0, 0, 0, 32'h0001_0000, 32'h0, 0, acc1, wt);
        drain();
        check_eq("ld_no_writes", wlog.size(), 0);

        // Byte loads (signed select) and a byte store
        lsu_req(0, 1, 1, 32'h0001_0003, 32'h0, 0, acc1, wt);
        drain();
        lsu_req(0, 1, 0, 32'h0001_0001, 32'h0, 0, acc1, wt);
        drain();
        wlog.delete();
        lsu_req(1, 1, 0, 32'h0001_0002, 32'h1234_5677, 0, acc1, wt);
        drain();
        check_eq("bst_writes", wlog.size(), 1);
        if (wlog.size() == 1) check_eq("bst_b0", wlog[0], {32'h0001_0002, 8'h77});
        lsu_req(0, 0, 0, 32'h0001_0000, 32'h0, 0, acc1, wt);
        drain();

        // Address wrap on a word store, then unaligned word load across the wrap
        wlog.delete();
        lsu_req(1, 0, 0, 32'hFFFF_FFFE, 32'h4433_2211, 0, acc1, wt);
        drain();
        a_exp[0] = 32'hFFFF_FFFE; a_exp[1] = 32'hFFFF_FFFF;
        a_exp[2] = 32'h0000_0000; a_exp[3] = 32'h0000_0001;
        check_eq("wrap_writes", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int k = 0; k < 4; k++) check_eq("wrap_addr", wlog[k][39:8], a_exp[k]);
        end
        lsu_req(0, 0, 0, 32'hFFFF_FFFE, 32'h0, 0, acc1, wt);
        drain();

        // Randomised mix, unaligned addresses allowed
        for (int i = 0; i < 10; i++) begin
            lsu_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'h300 + 32'($urandom_range(0, 250)), $urandom, 0, acc1, wt);
            drain();
        end

        // Back-to-back with req_valid held high throughout
        lsu_req(0, 0, 0, 32'h0001_0000, 32'h0, 1, acc1, wt);
        lsu_req(0, 1, 1, 32'h0001_0003, 32'h0, 0, acc2, wt);
        drain();
        check_eq("b2b_gap", acc2 - acc1, 6);
        check_eq("b2b_ready_low", wt, 5);

        // Reset during beat 1 of a word store aborts it
        wlog.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h500;
        req_wdata = 32'hA1B2_C3D4;
        @(negedge clk);
        check_eq("abort_accept", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ref_mem[12'h500] = 8'hD4;
        ref_mem[12'h501] = 8'hC3;
        last_load = 32'h0;
        @(negedge clk);
        check_eq("abort_ready", req_ready, 1);
        check_eq("abort_rsp_valid", rsp_valid, 0);
        check_eq("abort_mem_we", mem_we, 0);
        check_eq("abort_rdata", rsp_rdata, 0);
        repeat (8) @(negedge clk);
        check_eq("abort_writes", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check_eq("abort_b0", wlog[0], {32'h0000_0500, 8'hD4});
            check_eq("abort_b1", wlog[1], {32'h0000_0501, 8'hC3});
        end
        lsu_req(0, 0, 0, 32'h500, 32'h0, 0, acc1, wt);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
